instr_fetch: RTL and testbench

Instruction-fetch stage of the single-issue MIPS core. Owns the program counter, drives the word address into the combinational instruction ROM, and captures the returned word into the IF/ID pipeline register. Handles sequential advance, taken-branch redirect from EX, jump redirect from ID, decode stall, and out-of-range fetch halt.

---
 rtl/cpu_pkg.sv | 21 ++
 rtl/pc_next_calc.sv | 36 +++
 rtl/instr_fetch.sv | 95 +++++++++
 tb/tb_instr_fetch.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared constants and types for the MIPS fetch stage
package cpu_pkg;

  localparam logic [31:0] NOP_INST = 32'h0000_0000;

  // J-target layout: {pc_plus4[31:28], index[25:0], 2'b00}
  localparam int JT_HI_W  = 4;
  localparam int JT_IDX_W = 26;
  localparam int JT_LO_W  = 2;

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_t;

  function automatic logic addr_in_rom(input logic [31:0] addr, input logic [31:0] limit);
    return addr < limit;
  endfunction

endpackage

// File: rtl/pc_next_calc.sv
// rtl/pc_next_calc.sv - combinational next-PC selection for the fetch stage
module pc_next_calc
  import cpu_pkg::*;
(
  input  logic [31:0] pc,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_pc_plus4,
  input  logic [15:0] br_imm,
  input  logic        jump_en,
  input  logic [25:0] jump_index,
  input  logic [31:0] if_id_pc_plus4,
  output logic [31:0] pc_plus4,
  output logic [31:0] br_target,
  output logic [31:0] next_pc
);

  logic [31:0] jump_target;

  assign pc_plus4    = pc + 32'd4;
  assign br_target   = br_pc_plus4 + {{14{br_imm[15]}}, br_imm, 2'b00};
  assign jump_target = {if_id_pc_plus4[31:32-JT_HI_W], jump_index[JT_IDX_W-1:0], {JT_LO_W{1'b0}}};

  // Branch is the older instruction, so it beats both stall and jump.
  always_comb begin
    next_pc = pc_plus4;
    if (br_taken) begin
      next_pc = br_target;
    end else if (stall) begin
      next_pc = pc;
    end else if (jump_en) begin
      next_pc = jump_target;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - MIPS instruction fetch stage: PC, ROM address, IF/ID register
module instr_fetch
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter int          ROM_WORDS = 32
) (
  input  logic        Clk,
  input  logic        Rst_n,
  output logic [31:0] Addr,
  input  logic [31:0] Inst,
  input  logic        Stall,
  input  logic        BrTaken,
  input  logic [31:0] BrPcPlus4,
  input  logic [15:0] BrImm,
  input  logic        JumpEn,
  input  logic [25:0] JumpIndex,
  output logic [31:0] IfId_Inst,
  output logic [31:0] IfId_PcPlus4,
  output logic        IfId_Valid,
  output logic        Fault
);

  localparam logic [31:0] ROM_LIMIT = 32'(4 * ROM_WORDS);

  fetch_state_t state;
  logic [31:0]  pc;
  logic [31:0]  pc_plus4;
  logic [31:0]  br_target;
  logic [31:0]  next_pc;

  assign Addr = pc;

  pc_next_calc u_pc_next_calc (
    .pc             (pc),
    .stall          (Stall),
    .br_taken       (BrTaken),
    .br_pc_plus4    (BrPcPlus4),
    .br_imm         (BrImm),
    .jump_en        (JumpEn),
    .jump_index     (JumpIndex),
    .if_id_pc_plus4 (IfId_PcPlus4),
    .pc_plus4       (pc_plus4),
    .br_target      (br_target),
    .next_pc        (next_pc)
  );

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state        <= ST_BOOT;
      pc           <= RESET_VEC;
      IfId_Inst    <= NOP_INST;
      IfId_PcPlus4 <= 32'h0;
      IfId_Valid   <= 1'b0;
      Fault        <= 1'b0;
    end else begin
      case (state)
        ST_BOOT: begin
          state <= ST_RUN;
        end
        ST_RUN: begin
          if (!BrTaken && !Stall && !JumpEn && !addr_in_rom(pc, ROM_LIMIT)) begin
            IfId_Inst    <= NOP_INST;
            IfId_PcPlus4 <= 32'h0;
            IfId_Valid   <= 1'b0;
            Fault        <= 1'b1;
            state        <= ST_HALTED;
          end else begin
            pc <= next_pc;
            if (BrTaken || (!Stall && JumpEn)) begin
              IfId_Inst    <= NOP_INST;
              IfId_PcPlus4 <= 32'h0;
              IfId_Valid   <= 1'b0;
            end else if (!Stall) begin
              IfId_Inst    <= Inst;
              IfId_PcPlus4 <= pc_plus4;
              IfId_Valid   <= 1'b1;
            end
          end
        end
        ST_HALTED: begin
          // IF/ID is already a bubble; only a taken branch can restart fetch.
          if (BrTaken) begin
            pc    <= br_target;
            state <= addr_in_rom(br_target, ROM_LIMIT) ? ST_RUN : ST_HALTED;
          end
        end
        default: begin
          state <= ST_BOOT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed self-checking bench for instr_fetch
module tb_instr_fetch;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic [31:0] Addr;
  logic [31:0] Inst;
  logic        Stall;
  logic        BrTaken;
  logic [31:0] BrPcPlus4;
  logic [15:0] BrImm;
  logic        JumpEn;
  logic [25:0] JumpIndex;
  logic [31:0] IfId_Inst;
  logic [31:0] IfId_PcPlus4;
  logic        IfId_Valid;
  logic        Fault;

  logic [31:0] rom [32];
  int n_checks = 0;
  int n_fail   = 0;

  always #5 Clk = ~Clk;

  assign Inst = (Addr < 32'd128) ? rom[Addr[6:2]] : 32'h0;

  instr_fetch #(.RESET_VEC(32'h0), .ROM_WORDS(32)) dut (
    .Clk          (Clk),
    .Rst_n        (Rst_n),
    .Addr         (Addr),
    .Inst         (Inst),
    .Stall        (Stall),
    .BrTaken      (BrTaken),
    .BrPcPlus4    (BrPcPlus4),
    .BrImm        (BrImm),
    .JumpEn       (JumpEn),
    .JumpIndex    (JumpIndex),
    .IfId_Inst    (IfId_Inst),
    .IfId_PcPlus4 (IfId_PcPlus4),
    .IfId_Valid   (IfId_Valid),
    .Fault        (Fault)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk_ifid(input string tag, input logic [31:0] inst, input logic [31:0] pc4,
                          input logic valid);
    chk({tag, "_inst"}, IfId_Inst, inst);
    chk({tag, "_pc4"}, IfId_PcPlus4, pc4);
    chk({tag, "_valid"}, {31'h0, IfId_Valid}, {31'h0, valid});
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_addr"}, Addr, 32'h0);
    chk_ifid(tag, 32'h0, 32'h0, 1'b0);
    chk({tag, "_fault"}, {31'h0, Fault}, 32'h0);
  endtask

  task automatic boot_seq(input string tag);
    step();
    chk({tag, "_boot_valid"}, {31'h0, IfId_Valid}, 32'h0);
    chk({tag, "_boot_addr"}, Addr, 32'h0);
    step();
    chk_ifid({tag, "_w0"}, 32'h3C01_0003, 32'h4, 1'b1);
    chk({tag, "_w0_addr"}, Addr, 32'h4);
    step();
    chk_ifid({tag, "_w1"}, 32'h3402_000C, 32'h8, 1'b1);
  endtask

  initial begin
    #20000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "bench time limit expired");
  end

  initial begin
    for (int i = 0; i < 32; i++) rom[i] = 32'h2400_0000 | i;
    rom[0] = 32'h3C01_0003;
    rom[1] = 32'h3402_000C;
    Rst_n = 1'b0; Stall = 1'b0; BrTaken = 1'b0; BrPcPlus4 = 32'h0; BrImm = 16'h0;
    JumpEn = 1'b0; JumpIndex = 26'h0;

    step(); step();
    chk_reset_vals("rst");
    #2 Rst_n = 1'b1;
    boot_seq("start");

    // sequential to 0x10, then stall three cycles
    step();
    chk("seq_addr_c", Addr, 32'hC);
    step();
    chk("seq_addr_10", Addr, 32'h10);
    chk_ifid("seq_w3", 32'h2400_0003, 32'h10, 1'b1);
    Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_addr", Addr, 32'h10);
      chk_ifid("stall", 32'h2400_0003, 32'h10, 1'b1);
    end
    Stall = 1'b0;
    step();
    chk("unstall_addr", Addr, 32'h14);
    chk_ifid("unstall", 32'h2400_0004, 32'h14, 1'b1);

    // jump held off by stall, then taken
    JumpEn = 1'b1; JumpIndex = 26'h0D; Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("jstall_addr", Addr, 32'h14);
      chk_ifid("jstall", 32'h2400_0004, 32'h14, 1'b1);
    end
    Stall = 1'b0;
    step();
    chk("jump_addr", Addr, 32'h34);
    chk("jump_bubble", {31'h0, IfId_Valid}, 32'h0);
    JumpEn = 1'b0;
    step();
    chk_ifid("jump_tgt", 32'h2400_000D, 32'h38, 1'b1);
    chk("jump_next_addr", Addr, 32'h38);

    // forward branch
    BrTaken = 1'b1; BrPcPlus4 = 32'h1C; BrImm = 16'h0002;
    step();
    chk("br_addr", Addr, 32'h24);
    chk_ifid("br_bubble", 32'h0, 32'h0, 1'b0);
    BrTaken = 1'b0;
    step();
    chk_ifid("br_tgt", 32'h2400_0009, 32'h28, 1'b1);

    // negative branch beats concurrent stall and jump
    BrTaken = 1'b1; BrPcPlus4 = 32'h40; BrImm = 16'hFFFC; Stall = 1'b1; JumpEn = 1'b1;
    step();
    chk("nbr_addr", Addr, 32'h30);
    chk("nbr_bubble", {31'h0, IfId_Valid}, 32'h0);
    BrTaken = 1'b0; Stall = 1'b0; JumpEn = 1'b0;
    step();
    chk_ifid("nbr_tgt", 32'h2400_000C, 32'h34, 1'b1);

    // run off the end of the ROM
    BrTaken = 1'b1; BrPcPlus4 = 32'h7C; BrImm = 16'h0000;
    step();
    chk("oor_addr_7c", Addr, 32'h7C);
    BrTaken = 1'b0;
    step();
    chk_ifid("oor_last", 32'h2400_001F, 32'h80, 1'b1);
    chk("oor_addr_80", Addr, 32'h80);
    chk("oor_nofault", {31'h0, Fault}, 32'h0);
    step();
    chk("oor_fault", {31'h0, Fault}, 32'h1);
    chk("oor_bubble", {31'h0, IfId_Valid}, 32'h0);
    chk("oor_frozen", Addr, 32'h80);
    step();
    chk("halt_frozen", Addr, 32'h80);

    // halted: out-of-range branch target stays halted
    BrTaken = 1'b1; BrPcPlus4 = 32'h100; BrImm = 16'h0;
    step();
    chk("halt_br_oor", Addr, 32'h100);
    BrTaken = 1'b0;
    step();
    chk("halt_still", Addr, 32'h100);
    chk("halt_still_valid", {31'h0, IfId_Valid}, 32'h0);

    // wrapping branch sum back to 0 resumes RUN with Fault sticky
    BrTaken = 1'b1; BrPcPlus4 = 32'hFFFF_FFFC; BrImm = 16'h0001;
    step();
    chk("resume_addr", Addr, 32'h0);
    chk("resume_fault", {31'h0, Fault}, 32'h1);
    BrTaken = 1'b0;
    step();
    chk_ifid("resume_w0", 32'h3C01_0003, 32'h4, 1'b1);
    chk("resume_fault2", {31'h0, Fault}, 32'h1);

    // asynchronous reset pulse between edges
    step();
    #3 Rst_n = 1'b0;
    #1;
    chk_reset_vals("arst");
    #1 Rst_n = 1'b1;
    boot_seq("restart");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
